pg_seq: RTL and testbench

Power-gate sequencer for one switchable NVDLA partition. It drives the partition's clock enable, isolation, retention save/restore, power-switch enable and partition reset in a fixed, glitch-free order on power-down and power-up requests. It sits in the always-on domain next to the retention/always-on flops it controls and closes a level handshake with the power-management master.

---
 rtl/pg_seq_pkg.sv | 66 ++++++
 rtl/pg_seq_dly_cnt.sv | 27 ++
 rtl/pg_seq.sv | 127 ++++++++++++
 tb/tb_pg_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pg_seq_pkg.sv
// Shared types for the power-gate sequencer: the state encoding and the
// registered output vector that each state drives.
package pg_seq_pkg;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_SW_ON,
    ST_RESTORE,
    ST_RST_REL,
    ST_CLK_ON,
    ST_ISO_OFF,
    ST_ON,
    ST_CLK_OFF,
    ST_ISO_ON,
    ST_SAVE,
    ST_RST_ON,
    ST_SW_OFF
  } pg_state_t;

  typedef struct packed {
    logic sw_en;
    logic clk_en;
    logic iso_en;
    logic part_rst;
    logic ret_save;
    logic ret_restore;
    logic ack;
    logic busy;
  } pg_out_t;

  // Field order: sw_en clk_en iso_en part_rst ret_save ret_restore ack busy
  localparam pg_out_t OUT_OFF     = 8'b0011_0000;
  localparam pg_out_t OUT_SW_ON   = 8'b1011_0001;
  localparam pg_out_t OUT_RESTORE = 8'b1011_0101;
  localparam pg_out_t OUT_RST_REL = 8'b1010_0001;
  localparam pg_out_t OUT_CLK_ON  = 8'b1110_0001;
  localparam pg_out_t OUT_ISO_OFF = 8'b1100_0001;
  localparam pg_out_t OUT_ON      = 8'b1100_0010;
  localparam pg_out_t OUT_CLK_OFF = 8'b1000_0011;
  localparam pg_out_t OUT_ISO_ON  = 8'b1010_0011;
  localparam pg_out_t OUT_SAVE    = 8'b1010_1011;
  localparam pg_out_t OUT_RST_ON  = 8'b1011_0011;
  localparam pg_out_t OUT_SW_OFF  = 8'b0011_0011;
  localparam pg_out_t OUT_RST     = OUT_OFF;

  function automatic pg_out_t state_out(input pg_state_t s);
    pg_out_t o;
    o = OUT_OFF;
    case (s)
      ST_SW_ON:   o = OUT_SW_ON;
      ST_RESTORE: o = OUT_RESTORE;
      ST_RST_REL: o = OUT_RST_REL;
      ST_CLK_ON:  o = OUT_CLK_ON;
      ST_ISO_OFF: o = OUT_ISO_OFF;
      ST_ON:      o = OUT_ON;
      ST_CLK_OFF: o = OUT_CLK_OFF;
      ST_ISO_ON:  o = OUT_ISO_ON;
      ST_SAVE:    o = OUT_SAVE;
      ST_RST_ON:  o = OUT_RST_ON;
      ST_SW_OFF:  o = OUT_SW_OFF;
      default:    o = OUT_OFF;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pg_seq_dly_cnt.sv
// Load/decrement counter shared by the step delays and the switch-ack timeout;
// done is high while the count is zero.
module pg_seq_dly_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/pg_seq.sv
// pg_seq: power-gate sequencer for one switchable partition (always-on domain).
// Define PG_SEQ_RETENTION_EN to include the SAVE/RESTORE retention steps.
module pg_seq
  import pg_seq_pkg::*;
#(
  parameter int STEP_DLY    = 4,
  parameter int ACK_TIMEOUT = 256,
  parameter int CNT_W       = 9
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  input  logic pg_req,
  output logic pg_ack,
  output logic pg_busy,
  output logic pg_err,
  input  logic sw_ack,
  output logic sw_en,
  output logic clk_en,
  output logic iso_en,
  output logic ret_save,
  output logic ret_restore,
  output logic part_rst
);

  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);

  pg_state_t        state_reg, state_next;
  pg_out_t          out_reg, out_next;
  logic             err_reg, err_next;
  logic             blocked_reg, blocked_next;
  logic             cnt_load, cnt_done;
  logic [CNT_W-1:0] cnt_load_val;

  pg_seq_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_next   = state_reg;
    err_next     = err_reg;
    // A timed-out power-up stays blocked until pg_req has been seen low.
    blocked_next = pg_req ? blocked_reg : 1'b0;
    case (state_reg)
      ST_OFF:     if (pg_req && !blocked_reg) state_next = ST_SW_ON;
      ST_SW_ON: begin
        if (sw_ack) begin
`ifdef PG_SEQ_RETENTION_EN
          state_next = ST_RESTORE;
`else
          state_next = ST_RST_REL;
`endif
        end else if (cnt_done) begin
          state_next   = ST_OFF;
          err_next     = 1'b1;
          blocked_next = 1'b1;
        end
      end
      ST_RESTORE: if (cnt_done) state_next = ST_RST_REL;
      ST_RST_REL: if (cnt_done) state_next = ST_CLK_ON;
      ST_CLK_ON:  if (cnt_done) state_next = ST_ISO_OFF;
      ST_ISO_OFF: if (cnt_done) state_next = ST_ON;
      ST_ON:      if (!pg_req) state_next = ST_CLK_OFF;
      ST_CLK_OFF: if (cnt_done) state_next = ST_ISO_ON;
      ST_ISO_ON: begin
        if (cnt_done) begin
`ifdef PG_SEQ_RETENTION_EN
          state_next = ST_SAVE;
`else
          state_next = ST_RST_ON;
`endif
        end
      end
      ST_SAVE:    if (cnt_done) state_next = ST_RST_ON;
      ST_RST_ON:  if (cnt_done) state_next = ST_SW_OFF;
      ST_SW_OFF: begin
        if (!sw_ack) begin
          state_next = ST_OFF;
        end else if (cnt_done) begin
          state_next = ST_OFF;
          err_next   = 1'b1;
        end
      end
      default:    state_next = ST_OFF;
    endcase

    if (state_reg == ST_OFF && state_next == ST_SW_ON) err_next = 1'b0;

    cnt_load     = (state_next != state_reg);
    cnt_load_val = (state_next == ST_SW_ON || state_next == ST_SW_OFF) ? ACK_LOAD : STEP_LOAD;

    out_next = state_out(state_next);
`ifndef PG_SEQ_RETENTION_EN
    out_next.ret_save    = 1'b0;
    out_next.ret_restore = 1'b0;
`endif
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_reg   <= ST_OFF;
      out_reg     <= OUT_RST;
      err_reg     <= 1'b0;
      blocked_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      out_reg     <= out_next;
      err_reg     <= err_next;
      blocked_reg <= blocked_next;
    end
  end

  assign pg_ack      = out_reg.ack;
  assign pg_busy     = out_reg.busy;
  assign pg_err      = err_reg;
  assign sw_en       = out_reg.sw_en;
  assign clk_en      = out_reg.clk_en;
  assign iso_en      = out_reg.iso_en;
  assign ret_save    = out_reg.ret_save;
  assign ret_restore = out_reg.ret_restore;
  assign part_rst    = out_reg.part_rst;

endmodule

// File: tb/tb_pg_seq.sv
// Scoreboard bench for pg_seq: stimulus queues (cycle, output vector) pairs,
// a monitor pops one entry on every change of the output vector.
module tb_pg_seq;

  localparam int STEP_DLY    = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int D           = STEP_DLY;
`ifdef PG_SEQ_RETENTION_EN
  localparam bit RET = 1'b1;
  localparam int NT  = 4;
`else
  localparam bit RET = 1'b0;
  localparam int NT  = 3;
`endif

  // {pg_ack, pg_busy, pg_err, sw_en, clk_en, iso_en, part_rst, ret_save, ret_restore}
  localparam logic [8:0] V_OFF     = 9'b000_0011_00;
  localparam logic [8:0] V_OFF_ERR = 9'b001_0011_00;
  localparam logic [8:0] V_SW_ON   = 9'b010_1011_00;
  localparam logic [8:0] V_RESTORE = 9'b010_1011_01;
  localparam logic [8:0] V_RST_REL = 9'b010_1010_00;
  localparam logic [8:0] V_CLK_ON  = 9'b010_1110_00;
  localparam logic [8:0] V_ISO_OFF = 9'b010_1100_00;
  localparam logic [8:0] V_ON      = 9'b100_1100_00;
  localparam logic [8:0] V_CLK_OFF = 9'b110_1000_00;
  localparam logic [8:0] V_ISO_ON  = 9'b110_1010_00;
  localparam logic [8:0] V_SAVE    = 9'b110_1010_10;
  localparam logic [8:0] V_RST_ON  = 9'b110_1011_00;
  localparam logic [8:0] V_SW_OFF  = 9'b110_0011_00;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic pg_req = 1'b0;
  logic sw_ack = 1'b0;
  logic pg_ack, pg_busy, pg_err, sw_en, clk_en, iso_en, ret_save, ret_restore, part_rst;
  logic [8:0] vec;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
    string      name;
  } exp_t;
  exp_t q[$];

  pg_seq #(
    .STEP_DLY    (STEP_DLY),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (9)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .pg_req         (pg_req),
    .pg_ack         (pg_ack),
    .pg_busy        (pg_busy),
    .pg_err         (pg_err),
    .sw_ack         (sw_ack),
    .sw_en          (sw_en),
    .clk_en         (clk_en),
    .iso_en         (iso_en),
    .ret_save       (ret_save),
    .ret_restore    (ret_restore),
    .part_rst       (part_rst)
  );

  assign vec = {pg_ack, pg_busy, pg_err, sw_en, clk_en, iso_en, part_rst, ret_save, ret_restore};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [8:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic chk_now(input string nm, input logic [8:0] exp_v);
    checks++;
    if (vec !== exp_v) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", nm, vec, exp_v);
    end else begin
      $display("ok   %s vec=%b", nm, vec);
    end
  endtask

  // Raises pg_req, returns sw_ack ack_dly cycles after SW_ON entry; optional early drop.
  task automatic power_up(input int ack_dly, input bit drop, output int on);
    int n, m;
    @(negedge clk);
    pg_req = 1'b1;
    n  = cyc + 1;
    m  = n + ack_dly;
    on = m + NT * D;
    push(n, V_SW_ON, "sw_on");
    if (RET) begin
      push(m,       V_RESTORE, "restore");
      push(m + D,   V_RST_REL, "rst_rel");
      push(m + 2*D, V_CLK_ON,  "clk_on");
      push(m + 3*D, V_ISO_OFF, "iso_off");
    end else begin
      push(m,       V_RST_REL, "rst_rel");
      push(m + D,   V_CLK_ON,  "clk_on");
      push(m + 2*D, V_ISO_OFF, "iso_off");
    end
    push(on, V_ON, "on");
    while (cyc != on) begin
      if (cyc == m - 1) sw_ack = 1'b1;
      if (drop && cyc == n + 1) pg_req = 1'b0;
      @(negedge clk);
    end
  endtask

  // Power-down whose CLK_OFF entry edge is n; sw_ack drops 2 cycles after sw_en falls.
  task automatic power_down(input int n);
    int s;
    s = n + NT * D;
    push(n,     V_CLK_OFF, "clk_off");
    push(n + D, V_ISO_ON,  "iso_on");
    if (RET) begin
      push(n + 2*D, V_SAVE,   "save");
      push(n + 3*D, V_RST_ON, "rst_on");
    end else begin
      push(n + 2*D, V_RST_ON, "rst_on");
    end
    push(s,     V_SW_OFF, "sw_off");
    push(s + 2, V_OFF,    "off");
    while (cyc != s + 1) @(negedge clk);
    sw_ack = 1'b0;
    while (cyc != s + 2) @(negedge clk);
  endtask

  initial begin : monitor
    logic [8:0] prev;
    exp_t       e;
    wait (started);
    prev = vec;
    forever begin
      @(negedge clk);
      if (vec !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%b at cyc %0d, expected no change", vec, cyc);
        end else begin
          e = q.pop_front();
          if (vec !== e.vec || cyc != e.cyc) begin
            failures++;
            $display("FAIL %s got=%b at cyc %0d, expected=%b at cyc %0d",
                     e.name, vec, cyc, e.vec, e.cyc);
          end else begin
            $display("ok   %s vec=%b cyc=%0d", e.name, vec, cyc);
          end
        end
        prev = vec;
      end
    end
  end

  initial begin : stim
    int on, n, p;
    repeat (3) @(negedge clk);
    chk_now("reset_state", V_OFF);
    rst     = 1'b0;
    started = 1'b1;

    // Basic power-up (ack 3 cycles after sw_en) and power-down.
    power_up(3, 1'b0, on);
    @(negedge clk);
    pg_req = 1'b0;
    power_down(cyc + 1);

    // Switch-ack timeout, blocked retry, then one-cycle low re-arms the request.
    @(negedge clk);
    pg_req = 1'b1;
    n = cyc + 1;
    push(n, V_SW_ON, "to_sw_on");
    push(n + ACK_TIMEOUT, V_OFF_ERR, "ack_timeout");
    while (cyc != n + ACK_TIMEOUT + 10) @(negedge clk);
    pg_req = 1'b0;
    power_up(1, 1'b0, on);
    @(negedge clk);
    pg_req = 1'b0;
    power_down(cyc + 1);

    // Request dropped two cycles into power-up.
    power_up(3, 1'b1, on);
    power_down(on + 1);

    // Asynchronous reset in the middle of the power-down path.
    power_up(2, 1'b0, on);
    @(negedge clk);
    pg_req = 1'b0;
    n = cyc + 1;
    push(n,     V_CLK_OFF, "clk_off");
    push(n + D, V_ISO_ON,  "iso_on");
    if (RET) begin
      push(n + 2*D, V_SAVE, "save");
      p = n + 2*D + 1;
    end else begin
      p = n + D + 1;
    end
    push(p + 1, V_OFF, "async_reset_seen");
    while (cyc != p) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_now("async_reset_now", V_OFF);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    sw_ack = 1'b0;

    // FSM must be in OFF after reset: a fresh request starts immediately.
    power_up(1, 1'b0, on);
    @(negedge clk);
    pg_req = 1'b0;
    power_down(cyc + 1);

    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d outstanding, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
